rc4_ksa_engine: RTL and testbench
=================================

# rc4_ksa_engine

Parametrised, single-clock RC4 key-scheduling engine for the decryption datapath. It replaces the strobe-driven shuffle step with a self-sequencing FSM. A single `start` runs an optional identity fill of the S-array memory and the full KSA swap loop over all 2^ADDR_W entries, with a `done` pulse at the end. It sits between the top-level control FSM and the single-port S-array RAM, and owns that RAM's port while `busy` is high.

## Interface
Parameters:
- `KEY_BYTES`, 3: secret key length in bytes; legal range 1..32.
- `ADDR_W`, 8: S-array address width. Depth is 2^ADDR_W. Data width equals ADDR_W.
- `RD_LAT`, 1: RAM read latency in cycles from address presented to `mem_rdata` valid; legal range 1..4.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `init_en`  in  1  sampled with `start`. 1 runs the FILL phase (S[x]=x) before the shuffle.
- `key`  in  8*KEY_BYTES  secret key. Byte k is `key[8k+7:8k]`. Registered on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of run.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  ADDR_W  RAM write data.
- `mem_wren`  out  1  RAM write enable.
- `mem_rdata`  in  ADDR_W  RAM read data.

## Operation
- Sequencing is handled by the state machine below. Registers: `i`, `j`, `kidx`, `si`, `sj`, `key_q`, and a latency counter `lat`.
- **IDLE**: outputs idle. On `start`, capture `key_q`, clear `i`, `j` and `kidx`, then go to FILL if `init_en`, otherwise to RD_I.
- **FILL**: write `mem_addr=i`, `mem_wdata=i`, `mem_wren=1`, and increment `i`. When `i` wraps to 0, go to RD_I.
- **RD_I**: `mem_addr=i`, `mem_wren=0`. Load `lat=RD_LAT`, then go to WAIT_I.
- **WAIT_I**: hold the address and decrement `lat`. At `lat==1`, capture `si=mem_rdata`, set `j = j + si + keybyte(kidx)` mod 2^ADDR_W, then go to RD_J.
  - The key byte is truncated or zero-extended to ADDR_W.
- **RD_J / WAIT_J**: same as RD_I / WAIT_I, but on `j`, and capture `sj`.
- **WR_I**: `mem_addr=i`, `mem_wdata=sj`, `mem_wren=1`.
- **WR_J**: `mem_addr=j`, `mem_wdata=si`, `mem_wren=1`.
  - Increment `i`.
  - Set `kidx = (kidx==KEY_BYTES-1) ? 0 : kidx+1`. No modulo or divide hardware.
  - If `i` was 2^ADDR_W-1, go to DONE; otherwise go to RD_I.
- **DONE**: `done=1`, `busy=0` for one cycle, then return to IDLE.
- Boundary behaviour:
  - **i==j**: both writes occur. WR_J overwrites with the same value, so the entry is unchanged.
  - **start while busy**: ignored.
  - **key changes mid-run**: ignored, because only `key_q` is used.
  - **KEY_BYTES=1**: `kidx` stays 0.

## Timing
- Reset value of every output is 0: `busy`, `done`, `mem_addr`, `mem_wdata`, `mem_wren`. The FSM resets to IDLE and all internal registers clear.
- Reset mid-run aborts on the next edge. RAM contents are left partially shuffled.
- All outputs are registered-state decodes, with no combinational path from `mem_rdata` to outputs.
- FILL takes 2^ADDR_W cycles.
- Each shuffle iteration takes 4 + 2*RD_LAT cycles.
- Total latency from the accepted `start` edge to `done` high:
  - with FILL: 2^ADDR_W*(5+2*RD_LAT) + 1 cycles;
  - without FILL: 2^ADDR_W*(4+2*RD_LAT) + 1 cycles.
- Default parameters with FILL: 1793 cycles.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Package `rc4_pkg` holds:
  - the `ksa_state_t` enum (IDLE, FILL, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE);
  - a `ksa_cycles(ADDR_W, RD_LAT, init)` function used by the bench;
  - the `KEY_BYTE_W=8` constant.
- One sub-module, `rc4_key_sel`, contains `key_q`, the wrapping `kidx` counter, and the byte mux. Its inputs are `load`, `advance` and `clear`; its output is `keybyte`.

## Test plan
- FILL only: defaults, `key=0`, `init_en=1`. Snoop writes: entries 0..255 are written with x at address x during cycles 1..256.
- First swaps: `key=0x030201`.
  - Iteration 0: j=1, writes S[0]=1 and S[1]=0.
  - Iteration 1: j=3, writes S[1]=3 and S[3]=0.
- Full run: `key=0x4F2A1B`, compared against a software RC4 KSA model. The final 256-entry array matches exactly, and `done` rises 1793 cycles after `start`.
- Latency variant: `RD_LAT=2`, `init_en=0`, on a preloaded identity RAM. `done` rises at cycle 2049, and the array still matches the model.
- Robustness:
  - pulse `start` and change `key` while `busy`: no effect on the result;
  - assert `reset` at iteration 100: next cycle `busy=0`, `mem_wren=0`, state IDLE;
  - a subsequent run completes correctly.
- `KEY_BYTES=1`, `key=0x07`: every iteration adds 0x07, and the result matches the model.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
// Included by the engine, its key selector and the bench.
package rc4_pkg;

  localparam int KEY_BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  // Cycles from the accepted start edge to done high.
  function automatic int ksa_cycles(
    input int addr_w,
    input int rd_lat,
    input bit init
  );
    int per;
    per = 4 + 2 * rd_lat + (init ? 1 : 0);
    return (1 << addr_w) * per + 1;
  endfunction

endpackage

// File: rtl/rc4_key_sel.sv
// Key register plus wrapping byte index for the KSA loop.
// Index wraps by compare, so no divider is needed.
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load,
  input  logic                            advance,
  input  logic                            clear,
  input  logic [KEY_BYTE_W*KEY_BYTES-1:0] key,
  output logic [KEY_BYTE_W-1:0]           keybyte
);

  localparam int KIDX_W =
    (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_MAX =
    KIDX_W'(KEY_BYTES - 1);

  logic [KEY_BYTES-1:0][KEY_BYTE_W-1:0] key_q;
  logic [KEY_BYTES-1:0][KEY_BYTE_W-1:0] key_d;
  logic [KIDX_W-1:0]                    kidx_q;
  logic [KIDX_W-1:0]                    kidx_d;

  always_comb begin
    key_d  = load ? key : key_q;
    kidx_d = kidx_q;
    if (clear) begin
      kidx_d = '0;
    end else if (advance) begin
      kidx_d = (kidx_q == KIDX_MAX) ? '0
             : kidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q  <= '0;
      kidx_q <= '0;
    end else begin
      key_q  <= key_d;
      kidx_q <= kidx_d;
    end
  end

  generate
    if (KEY_BYTES == 1) begin : g_one
      assign keybyte = key_q[0];
    end else begin : g_mux
      assign keybyte = key_q[kidx_q];
    end
  endgenerate

endmodule

// File: rtl/rc4_ksa_engine.sv
// Self-sequencing RC4 KSA: optional identity fill, then the swap
// loop over the whole S-array through a single-port RAM.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            init_en,
  input  logic [KEY_BYTE_W*KEY_BYTES-1:0] key,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [ADDR_W-1:0]               mem_wdata,
  output logic                            mem_wren,
  input  logic [ADDR_W-1:0]               mem_rdata
);

  localparam logic [ADDR_W-1:0] I_MAX    = '1;
  localparam logic [2:0]        LAT_INIT = 3'(RD_LAT);

  ksa_state_t        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] si_q, si_d;
  logic [ADDR_W-1:0] sj_q, sj_d;
  logic [2:0]        lat_q, lat_d;
  logic              load;
  logic              advance;
  logic [KEY_BYTE_W-1:0] keybyte;
  logic [ADDR_W-1:0] kb_ext;

  rc4_key_sel #(
    .KEY_BYTES(KEY_BYTES)
  ) u_key_sel (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .clear  (load),
    .key    (key),
    .keybyte(keybyte)
  );

  assign kb_ext = ADDR_W'(keybyte);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    lat_d   = lat_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = init_en ? FILL : RD_I;
        end
      end
      FILL: begin
        i_d = i_q + 1'b1;
        if (i_q == I_MAX) state_d = RD_I;
      end
      RD_I: begin
        lat_d   = LAT_INIT;
        state_d = WAIT_I;
      end
      WAIT_I: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == 3'd1) begin
          si_d    = mem_rdata;
          j_d     = j_q + mem_rdata + kb_ext;
          state_d = RD_J;
        end
      end
      RD_J: begin
        lat_d   = LAT_INIT;
        state_d = WAIT_J;
      end
      WAIT_J: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == 3'd1) begin
          sj_d    = mem_rdata;
          state_d = WR_I;
        end
      end
      WR_I: state_d = WR_J;
      WR_J: begin
        i_d     = i_q + 1'b1;
        advance = 1'b1;
        state_d = (i_q == I_MAX) ? DONE : RD_I;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      lat_q   <= lat_d;
    end
  end

  // Outputs decode registered state only; mem_rdata never reaches them.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state_q)
      FILL: begin
        busy      = 1'b1;
        mem_addr  = i_q;
        mem_wdata = i_q;
        mem_wren  = 1'b1;
      end
      RD_I, WAIT_I: begin
        busy     = 1'b1;
        mem_addr = i_q;
      end
      RD_J, WAIT_J: begin
        busy     = 1'b1;
        mem_addr = j_q;
      end
      WR_I: begin
        busy      = 1'b1;
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_wren  = 1'b1;
      end
      WR_J: begin
        busy      = 1'b1;
        mem_addr  = j_q;
        mem_wdata = si_q;
        mem_wren  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three configurations against a
// software RC4 KSA model with per-cycle write/handshake checks.
module tb_rc4_ksa_engine;
  import rc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [3];
  logic       start   [3];
  logic       init_en [3];
  logic [23:0] key    [3];
  logic       busy    [3];
  logic       done    [3];
  logic       wren    [3];
  logic [7:0] addr    [3];
  logic [7:0] wdata   [3];
  logic [7:0] rdata   [3];
  logic [7:0] ram     [3][256];
  logic [7:0] st1     [3];
  logic [7:0] st2     [3];
  bit         pre     [3];

  logic [7:0] exp_a [3][768];
  logic [7:0] exp_d [3][768];
  int         exp_c [3][768];
  logic [7:0] exp_s [3][256];
  int exp_n    [3] = '{0, 0, 0};
  int exp_p    [3] = '{0, 0, 0};
  int exp_done [3] = '{0, 0, 0};
  bit armed    [3] = '{0, 0, 0};
  int cyc      [3] = '{0, 0, 0};

  int checks = 0;
  int errors = 0;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int KB = (g == 2) ? 1 : 3;
      localparam int RL = (g == 1) ? 2 : 1;
      rc4_ksa_engine #(
        .KEY_BYTES(KB),
        .ADDR_W   (8),
        .RD_LAT   (RL)
      ) u_dut (
        .clk      (clk),
        .reset    (rst[g]),
        .start    (start[g]),
        .init_en  (init_en[g]),
        .key      (key[g][8*KB-1:0]),
        .busy     (busy[g]),
        .done     (done[g]),
        .mem_addr (addr[g]),
        .mem_wdata(wdata[g]),
        .mem_wren (wren[g]),
        .mem_rdata(rdata[g])
      );
      assign rdata[g] = (RL == 2) ? st2[g] : st1[g];
    end
  endgenerate

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (pre[m]) begin
        for (int x = 0; x < 256; x++) ram[m][x] <= 8'(x);
      end else if (wren[m]) begin
        ram[m][addr[m]] <= wdata[m];
      end
      st1[m] <= ram[m][addr[m]];
      st2[m] <= st1[m];
    end
  end

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int kbytes(input int m);
    return (m == 2) ? 1 : 3;
  endfunction

  function automatic int rdlat(input int m);
    return (m == 1) ? 2 : 1;
  endfunction

  // Plain RC4 KSA, logging each RAM write with its cycle number.
  task automatic build(input int m, input logic [23:0] k,
                       input bit fill);
    int s [256];
    int n, c, jj, t, kb, rl, kv;
    logic [23:0] kk;
    kk = k;
    kb = kbytes(m);
    rl = rdlat(m);
    n  = 0;
    jj = 0;
    for (int x = 0; x < 256; x++)
      s[x] = fill ? x : int'(ram[m][x]);
    if (fill) begin
      for (int x = 0; x < 256; x++) begin
        exp_a[m][n] = 8'(x);
        exp_d[m][n] = 8'(x);
        exp_c[m][n] = 1 + x;
        n++;
      end
    end
    for (int ii = 0; ii < 256; ii++) begin
      c  = (fill ? 256 : 0) + 1 + ii * (4 + 2 * rl);
      kv = int'(kk[8*(ii%kb) +: 8]);
      jj = (jj + s[ii] + kv) % 256;
      t      = s[ii];
      s[ii]  = s[jj];
      s[jj]  = t;
      exp_a[m][n] = 8'(ii);
      exp_d[m][n] = 8'(s[ii]);
      exp_c[m][n] = c + 2 * rl + 2;
      n++;
      exp_a[m][n] = 8'(jj);
      exp_d[m][n] = 8'(t);
      exp_c[m][n] = c + 2 * rl + 3;
      n++;
    end
    for (int x = 0; x < 256; x++) exp_s[m][x] = 8'(s[x]);
    exp_n[m]    = n;
    exp_p[m]    = 0;
    exp_done[m] = ksa_cycles(8, rl, fill);
  endtask

  initial begin
    int p;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        if (armed[m] && rst[m]) begin
          armed[m] = 1'b0;
        end else if (armed[m]) begin
          cyc[m]++;
          if (wren[m]) begin
            p = exp_p[m];
            if (p < exp_n[m]) begin
              chk(addr[m] == exp_a[m][p] &&
                  wdata[m] == exp_d[m][p] &&
                  cyc[m] == exp_c[m][p],
                  "write cyc*65536+addr*256+data",
                  cyc[m] * 65536 + int'(addr[m]) * 256
                    + int'(wdata[m]),
                  exp_c[m][p] * 65536 + int'(exp_a[m][p]) * 256
                    + int'(exp_d[m][p]));
              exp_p[m]++;
            end else begin
              chk(1'b0, "extra_write_addr", int'(addr[m]), -1);
            end
          end
          if (cyc[m] < exp_done[m]) begin
            chk(busy[m] && !done[m], "busy_done_running",
                int'({busy[m], done[m]}), 2);
          end else begin
            chk(done[m] && !busy[m], "busy_done_end",
                int'({busy[m], done[m]}), 1);
            chk(exp_p[m] == exp_n[m], "write_count",
                exp_p[m], exp_n[m]);
            armed[m] = 1'b0;
          end
        end else if (start[m] && !busy[m] && !done[m] &&
                     !rst[m]) begin
          armed[m] = 1'b1;
          cyc[m]   = 0;
        end
      end
    end
  end

  task automatic run(input int m, input logic [23:0] k,
                     input bit fill, input bit disturb,
                     input int lat_exp);
    bit seen;
    int c;
    seen = 1'b0;
    c = 0;
    repeat (2) @(posedge clk);
    #2;
    build(m, k, fill);
    key[m]     = k;
    init_en[m] = fill;
    start[m]   = 1'b1;
    @(posedge clk);
    #2;
    start[m]   = 1'b0;
    init_en[m] = 1'b0;
    for (c = 0; c < 5000; c++) begin
      @(posedge clk);
      #2;
      if (disturb && c == 300) begin
        start[m] = 1'b1;
        key[m]   = ~k;
      end
      if (disturb && c == 302) start[m] = 1'b0;
      if (done[m]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "done_seen", int'(seen), 1);
    chk(c + 2 == lat_exp, "done_latency", c + 2, lat_exp);
    for (int x = 0; x < 256; x++)
      chk(ram[m][x] == exp_s[m][x], "s_array",
          int'(ram[m][x]), int'(exp_s[m][x]));
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      rst[m]     = 1'b1;
      start[m]   = 1'b0;
      init_en[m] = 1'b0;
      key[m]     = '0;
      pre[m]     = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int m = 0; m < 3; m++) begin
      chk(!busy[m], "reset_busy", int'(busy[m]), 0);
      chk(!done[m], "reset_done", int'(done[m]), 0);
      chk(!wren[m], "reset_wren", int'(wren[m]), 0);
      chk(addr[m] == 8'd0, "reset_addr", int'(addr[m]), 0);
      chk(wdata[m] == 8'd0, "reset_wdata", int'(wdata[m]), 0);
    end
    for (int m = 0; m < 3; m++) rst[m] = 1'b0;

    build(0, 24'h030201, 1'b1);
    chk(exp_a[0][256] == 8'd0, "model_it0_wi_addr",
        int'(exp_a[0][256]), 0);
    chk(exp_d[0][256] == 8'd1, "model_it0_wi_data",
        int'(exp_d[0][256]), 1);
    chk(exp_a[0][257] == 8'd1, "model_it0_wj_addr",
        int'(exp_a[0][257]), 1);
    chk(exp_d[0][257] == 8'd0, "model_it0_wj_data",
        int'(exp_d[0][257]), 0);
    chk(exp_a[0][258] == 8'd1, "model_it1_wi_addr",
        int'(exp_a[0][258]), 1);
    chk(exp_d[0][258] == 8'd3, "model_it1_wi_data",
        int'(exp_d[0][258]), 3);
    chk(exp_a[0][259] == 8'd3, "model_it1_wj_addr",
        int'(exp_a[0][259]), 3);
    chk(exp_d[0][259] == 8'd0, "model_it1_wj_data",
        int'(exp_d[0][259]), 0);
    chk(exp_c[0][256] == 261, "model_it0_wi_cycle",
        exp_c[0][256], 261);

    run(0, 24'h000000, 1'b1, 1'b0, 1793);
    run(0, 24'h030201, 1'b1, 1'b0, 1793);
    run(0, 24'h4F2A1B, 1'b1, 1'b1, 1793);

    pre[1] = 1'b1;
    @(posedge clk);
    #2;
    pre[1] = 1'b0;
    run(1, 24'h4F2A1B, 1'b0, 1'b0, 2049);

    repeat (2) @(posedge clk);
    #2;
    build(0, 24'h123456, 1'b1);
    key[0]     = 24'h123456;
    init_en[0] = 1'b1;
    start[0]   = 1'b1;
    @(posedge clk);
    #2;
    start[0]   = 1'b0;
    init_en[0] = 1'b0;
    repeat (856) @(posedge clk);
    #2;
    chk(busy[0], "pre_reset_busy", int'(busy[0]), 1);
    rst[0] = 1'b1;
    @(posedge clk);
    #2;
    chk(!busy[0], "abort_busy", int'(busy[0]), 0);
    chk(!wren[0], "abort_wren", int'(wren[0]), 0);
    chk(g_dut[0].u_dut.state_q == IDLE, "abort_state",
        int'(g_dut[0].u_dut.state_q), int'(IDLE));
    rst[0] = 1'b0;

    run(0, 24'hA5C3E1, 1'b1, 1'b0, 1793);
    run(2, 24'h000007, 1'b1, 1'b0, 1793);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
